regfile_alu_datapath: RTL and testbench
=======================================

REGFILE_ALU_DATAPATH -- requirements
Module: regfile_alu_datapath

Interface
REQ-001 Parameter WIDTH, default 16, data width of registers, ALU operands and result.
REQ-002 Parameter DEPTH, default 16, number of registers; ADDR_W = ceil(log2(DEPTH)).
REQ-003 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-006 op  input  4  ALU operation code (REQ-014).
REQ-007 dst, src_a, src_b  input  ADDR_W each  destination and source register addresses.
REQ-008 imm  input  WIDTH  immediate operand; use_imm  input  1  selects imm instead of register src_b as operand B.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 done  output  1  one-cycle pulse in the WRITE cycle.
REQ-011 result  output  WIDTH  registered ALU result of the last completed operation.
REQ-012 flags  output  4  registered {Z,N,C,V} of the last completed operation.
REQ-013 dbg_addr  input  ADDR_W, dbg_data  output  WIDTH  combinational read of the register file for display/debug.

Function
REQ-014 op codes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 logical, 8 SRA A by 1, 9 PASS B, 10 SLT signed (result 1 if A<B signed else 0), 11 ADC (A+B+C flag); 12-15 PASS A.
REQ-015 FSM states IDLE, READ, EXEC, WRITE; IDLE->READ on start=1; READ->EXEC, EXEC->WRITE, WRITE->IDLE unconditionally.
REQ-016 In IDLE with start=1, op, dst, src_a, src_b, imm, use_imm are captured; later input changes do not affect the operation.
REQ-017 READ: operand A = reg[src_a], operand B = use_imm ? imm : reg[src_b], both registered.
REQ-018 EXEC: result and flags computed and registered; result/flags outputs update at end of EXEC.
REQ-019 WRITE: reg[dst] <= result unless dst==0; done=1 for exactly this cycle.
REQ-020 Latency: start accepted at cycle T -> done high at T+3 -> ready high at T+4; next start accepted at T+4 earliest.
REQ-021 start while ready=0 ignored, no queuing.
REQ-022 Register 0 reads as 0 on all read ports (src_a, src_b, dbg); writes to it discarded.
REQ-023 Arithmetic modulo 2^WIDTH; Z = (result==0); N = result[WIDTH-1].
REQ-024 ADD/ADC: C = carry out of bit WIDTH-1; V = signed overflow.
REQ-025 SUB: C = 1 when A>=B unsigned (no borrow); V = signed overflow of A-B.
REQ-026 SHL/SHR/SRA: C = bit shifted out; V = 0. All other ops: C = 0, V = 0.
REQ-027 ADC uses the C flag value held in flags at the start of EXEC.
REQ-028 Addresses >= DEPTH (non-power-of-two DEPTH): reads return 0, writes discarded.

Reset
REQ-029 reset=1 at any clock edge: FSM -> IDLE, all registers, result, flags -> 0, done=0, ready=1 the cycle after.
REQ-030 reset during READ/EXEC/WRITE aborts the operation; no register write, no done pulse.
REQ-031 reset has priority over start in the same cycle.

Verification (WIDTH=16, DEPTH=16)
REQ-032 After reset: dbg_data=0 for all 16 addresses, result=0, flags=0000, ready=1.
REQ-033 PASS B imm=0x7FFF dst=1; PASS B imm=0x0001 dst=2; ADD dst=3 a=1 b=2 -> done at T+3, reg3=0x8000, flags Z0 N1 C0 V1.
REQ-034 SUB dst=4 a=2 b=2 -> reg4=0x0000, flags Z1 N0 C1 V0; then SUB a=0 b=2 -> 0xFFFF, C0 N1.
REQ-035 PASS B imm=0x1234 dst=0 -> done pulses, dbg_addr=0 reads 0x0000; ADC after ADD 0xFFFF+0x0001 (C=1) of 0+0 -> 0x0001.
REQ-036 start pulses in READ, EXEC and WRITE cycles -> ignored, exactly one done per accepted start; reset asserted in EXEC -> no done, dst register unchanged (0).

Source files
------------

// File: rtl/regfile_alu_datapath.sv
// Register file plus ALU datapath. A four-state sequencer executes one
// captured operation per request: read operands, execute, write back.
module regfile_alu_datapath #(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [WIDTH-1:0]  imm,
  input  logic              use_imm,
  output logic              ready,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam int unsigned MSB  = WIDTH - 1;

  // Bit i set when register i is writable and readable; excludes the
  // hard-zero register 0 and any address past DEPTH.
  localparam logic [NREG-1:0] VALID_MASK =
    ((NREG'(1) << DEPTH) - NREG'(1)) & ~NREG'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_PASB = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_ADC  = 4'd11;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [WIDTH-1:0]  imm;
    logic              use_imm;
  } cmd_t;

  state_t            state;
  cmd_t              cmd;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  regs [NREG];

  logic [WIDTH-1:0]  rd_a_c;
  logic [WIDTH-1:0]  rd_b_c;
  logic [WIDTH:0]    sum_c;
  logic [WIDTH-1:0]  alu_res_c;
  logic              alu_c_c;
  logic              alu_v_c;
  logic              alu_z_c;
  logic              alu_n_c;

  assign rd_a_c   = VALID_MASK[cmd.src_a] ? regs[cmd.src_a] : '0;
  assign rd_b_c   = VALID_MASK[cmd.src_b] ? regs[cmd.src_b] : '0;
  assign dbg_data = VALID_MASK[dbg_addr]  ? regs[dbg_addr]  : '0;

  // ALU on the registered operands; ADC consumes the carry currently held in flags.
  always_comb begin
    sum_c     = '0;
    alu_res_c = a_q;
    alu_c_c   = 1'b0;
    alu_v_c   = 1'b0;
    case (cmd.op)
      OP_ADD: begin
        sum_c     = {1'b0, a_q} + {1'b0, b_q};
        alu_res_c = sum_c[WIDTH-1:0];
        alu_c_c   = sum_c[WIDTH];
        alu_v_c   = (a_q[MSB] == b_q[MSB]) && (alu_res_c[MSB] != a_q[MSB]);
      end
      OP_ADC: begin
        sum_c     = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(flags[1]);
        alu_res_c = sum_c[WIDTH-1:0];
        alu_c_c   = sum_c[WIDTH];
        alu_v_c   = (a_q[MSB] == b_q[MSB]) && (alu_res_c[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        sum_c     = {1'b0, a_q} - {1'b0, b_q};
        alu_res_c = sum_c[WIDTH-1:0];
        alu_c_c   = ~sum_c[WIDTH];
        alu_v_c   = (a_q[MSB] != b_q[MSB]) && (alu_res_c[MSB] != a_q[MSB]);
      end
      OP_AND:  alu_res_c = a_q & b_q;
      OP_OR:   alu_res_c = a_q | b_q;
      OP_XOR:  alu_res_c = a_q ^ b_q;
      OP_NOT:  alu_res_c = ~a_q;
      OP_SHL: begin
        alu_res_c = {a_q[WIDTH-2:0], 1'b0};
        alu_c_c   = a_q[MSB];
      end
      OP_SHR: begin
        alu_res_c = {1'b0, a_q[WIDTH-1:1]};
        alu_c_c   = a_q[0];
      end
      OP_SRA: begin
        alu_res_c = {a_q[MSB], a_q[WIDTH-1:1]};
        alu_c_c   = a_q[0];
      end
      OP_PASB: alu_res_c = b_q;
      OP_SLT:  alu_res_c = WIDTH'($signed(a_q) < $signed(b_q));
      default: alu_res_c = a_q;
    endcase
    alu_z_c = (alu_res_c == '0);
    alu_n_c = alu_res_c[MSB];
  end

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state  <= IDLE;
      cmd    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      flags  <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cmd   <= '{op: op, dst: dst, src_a: src_a, src_b: src_b,
                       imm: imm, use_imm: use_imm};
            ready <= 1'b0;
            state <= READ;
          end
        end
        READ: begin
          a_q   <= rd_a_c;
          b_q   <= cmd.use_imm ? cmd.imm : rd_b_c;
          state <= EXEC;
        end
        EXEC: begin
          result <= alu_res_c;
          flags  <= {alu_z_c, alu_n_c, alu_c_c, alu_v_c};
          done   <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Write-back of the registered result; register 0 and out-of-range addresses drop the write.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == WRITE && VALID_MASK[cmd.dst]) begin
      regs[cmd.dst] <= result;
    end
  end

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Bench for regfile_alu_datapath: directed scenarios followed by random
// operations, all checked against an arithmetic reference model.
module tb_regfile_alu_datapath;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [3:0]  dst;
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [15:0] imm;
  logic        use_imm;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks   = 0;
  int failures = 0;
  int m_regs [16];
  int m_flags;
  int m_result;

  regfile_alu_datapath #(.WIDTH(16), .DEPTH(16)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dst      (dst),
    .src_a    (src_a),
    .src_b    (src_b),
    .imm      (imm),
    .use_imm  (use_imm),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .flags    (flags),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Reference: returns {Z,N,C,V, result[15:0]} from integer arithmetic.
  function automatic logic [19:0] model_alu(input int f_op, input int a, input int b, input int cin);
    int sa, sb, s, r;
    bit c, v;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    c = 0;
    v = 0;
    case (f_op)
      0, 11: begin
        s = a + b + ((f_op == 11) ? cin : 0);
        r = s % 65536;
        c = (s > 65535);
        s = sa + sb + ((f_op == 11) ? cin : 0);
        v = (s > 32767) || (s < -32768);
      end
      1: begin
        r = (a - b + 65536) % 65536;
        c = (a >= b);
        s = sa - sb;
        v = (s > 32767) || (s < -32768);
      end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 65535 - a;
      6:  begin r = (a * 2) % 65536; c = (a >= 32768); end
      7:  begin r = a / 2; c = (a % 2) == 1; end
      8:  begin r = (sa >>> 1) & 65535; c = (a % 2) == 1; end
      9:  r = b;
      10: r = (sa < sb) ? 1 : 0;
      default: r = a;
    endcase
    return {bit'(r == 0), bit'(r >= 32768), c, v, 16'(r)};
  endfunction

  task automatic scramble();
    start   = 1'b1;
    op      = 4'($urandom);
    dst     = 4'($urandom);
    src_a   = 4'($urandom);
    src_b   = 4'($urandom);
    imm     = 16'($urandom);
    use_imm = 1'($urandom);
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_flags  = 0;
    m_result = 0;
  endtask

  // One complete operation with cycle-exact handshake checks; noisy mode
  // keeps hammering start and input fields while the operation is busy.
  task automatic do_op(input int f_op, input int f_dst, input int f_a, input int f_b,
                       input int f_imm, input bit f_use, input bit noisy);
    int a, b, dones;
    logic [19:0] e;
    a = m_regs[f_a];
    b = f_use ? f_imm : m_regs[f_b];
    e = model_alu(f_op, a, b, (m_flags >> 1) & 1);
    check("ready_before_start", ready, 1);
    op = 4'(f_op); dst = 4'(f_dst); src_a = 4'(f_a); src_b = 4'(f_b);
    imm = 16'(f_imm); use_imm = f_use; start = 1'b1;
    tick();
    check("ready_low_read", ready, 0);
    dones = int'(done);
    if (noisy) scramble(); else start = 1'b0;
    tick();
    dones += int'(done);
    check("no_done_before_write", dones, 0);
    if (noisy) scramble();
    tick();
    check("done_write", done, 1);
    check("ready_low_write", ready, 0);
    check("result", result, e[15:0]);
    check("flags", flags, e[19:16]);
    if (noisy) scramble();
    tick();
    start = 1'b0;
    check("done_cleared", done, 0);
    check("ready_idle", ready, 1);
    m_result = e[15:0];
    m_flags  = e[19:16];
    if (f_dst != 0) m_regs[f_dst] = e[15:0];
    dbg_addr = 4'(f_dst);
    #1;
    check("dbg_dst", dbg_data, m_regs[f_dst]);
    if (noisy) begin
      tick();
      check("no_queued_start", ready, 1);
      check("no_extra_done", done, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; dst = '0; src_a = '0; src_b = '0;
    imm = '0; use_imm = 1'b0; dbg_addr = '0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check($sformatf("reset_dbg%0d", i), dbg_data, 0);
    end

    // Overflow into the sign bit.
    do_op(9, 1, 0, 0, 16'h7FFF, 1, 0);
    do_op(9, 2, 0, 0, 16'h0001, 1, 0);
    do_op(0, 3, 1, 2, 0, 0, 0);
    dbg_addr = 4'd3; #1;
    check("add_reg3", dbg_data, 16'h8000);
    check("add_flags", flags, 4'b0101);

    // Equal subtraction then borrow.
    do_op(1, 4, 2, 2, 0, 0, 0);
    dbg_addr = 4'd4; #1;
    check("sub_eq_reg4", dbg_data, 16'h0000);
    check("sub_eq_flags", flags, 4'b1010);
    do_op(1, 5, 0, 2, 0, 0, 0);
    check("sub_borrow_result", result, 16'hFFFF);
    check("sub_borrow_flags", flags, 4'b0100);

    // Writes to register 0 are dropped.
    do_op(9, 0, 0, 0, 16'h1234, 1, 0);
    dbg_addr = 4'd0; #1;
    check("reg0_reads_zero", dbg_data, 16'h0000);

    // Carry chain into ADC.
    do_op(0, 6, 5, 2, 0, 0, 0);
    check("add_carry_flags", flags, 4'b1010);
    do_op(11, 7, 0, 0, 0, 0, 0);
    dbg_addr = 4'd7; #1;
    check("adc_reg7", dbg_data, 16'h0001);

    // Starts while busy are ignored and captured fields hold.
    do_op(4, 9, 5, 1, 0, 0, 1);
    do_op(8, 10, 3, 0, 0, 0, 1);

    // Reset during EXEC aborts the write and the done pulse.
    op = 4'd9; dst = 4'd8; imm = 16'hABCD; use_imm = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_done", done, 0);
    check("abort_ready", ready, 1);
    check("abort_result", result, 0);
    check("abort_flags", flags, 0);
    reset = 1'b0;
    tick();
    check("abort_no_late_done", done, 0);
    model_reset();
    dbg_addr = 4'd8; #1;
    check("abort_reg8", dbg_data, 0);
    dbg_addr = 4'd3; #1;
    check("abort_regs_cleared", dbg_data, 0);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    check("reset_priority_ready", ready, 1);
    tick();
    check("reset_priority_no_done", done, 0);

    // Random register contents, then random operations.
    for (int i = 1; i < 16; i++)
      do_op(9, i, 0, 0, int'(16'($urandom)), 1, 1'($urandom));
    for (int k = 0; k < 48; k++)
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'(16'($urandom)), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
